// File: rtl/dm_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Sits between the CPU load/store stage and a block-read data memory that
// returns a 4-word line per read and accepts one word per write.
// Optional build macro: CACHE_STATS_EN adds hit/miss/write event counters.
module dm_cache_controller #(
    parameter int unsigned NUM_LINES   = 4,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ready,
    output logic [31:0]  mem_address,
    output logic [31:0]  mem_write_data,
    output logic         mem_write,
    output logic         mem_read,
    input  logic [127:0] mem_read_data
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count,
    output logic [31:0]  write_count
`endif
);

    localparam int unsigned IDX  = $clog2(NUM_LINES);
    localparam int unsigned TagW = 30 - IDX;
    localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StFetch, StWrite, StResp} stateT;

    stateT            stateQ, stateD;
    logic [CntW-1:0]  cntQ, cntD;

    logic [NUM_LINES-1:0] validQ;
    logic [TagW-1:0]      tagQ  [NUM_LINES];
    logic [31:0]          dataQ [NUM_LINES][4];

    logic [31:0] rdataQ;
    logic [31:0] memAddrQ;
    logic [31:0] memWdataQ;

    logic [1:0]      offset;
    logic [IDX-1:0]  index;
    logic [TagW-1:0] tag;
    logic            hit;
    logic            acceptLoadHit;
    logic            acceptLoadMiss;
    logic            acceptStore;
    logic            fillNow;
    logic [31:0]     fetchWord;

    assign offset = cpu_addr[1:0];
    assign index  = cpu_addr[IDX+1:2];
    assign tag    = cpu_addr[31:IDX+2];
    assign hit    = validQ[index] && (tagQ[index] == tag);

    assign acceptLoadHit  = (stateQ == StIdle) && cpu_req && !cpu_we && hit;
    assign acceptLoadMiss = (stateQ == StIdle) && cpu_req && !cpu_we && !hit;
    assign acceptStore    = (stateQ == StIdle) && cpu_req && cpu_we;
    // Last FETCH cycle: memory line is valid and gets installed on this edge
    assign fillNow        = (stateQ == StFetch) && (cntQ == CntW'(1));

    // Pick the requested word out of the returned line (word0 is the MSW)
    always_comb begin
        fetchWord = mem_read_data[127:96];
        unique case (offset)
            2'd0: fetchWord = mem_read_data[127:96];
            2'd1: fetchWord = mem_read_data[95:64];
            2'd2: fetchWord = mem_read_data[63:32];
            2'd3: fetchWord = mem_read_data[31:0];
            default: fetchWord = mem_read_data[127:96];
        endcase
    end

    // State and latency counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StIdle;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    // Next-state and counter logic
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        unique case (stateQ)
            StIdle: begin
                if (cpu_req) begin
                    if (!cpu_we && hit) begin
                        stateD = StResp;
                    end else begin
                        cntD   = CntW'(MEM_LATENCY);
                        stateD = cpu_we ? StWrite : StFetch;
                    end
                end
            end
            StFetch, StWrite: begin
                cntD = cntQ - CntW'(1);
                if (cntQ == CntW'(1)) begin
                    stateD = StResp;
                end
            end
            StResp:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    // Strobes decode from state only; address/data hold when no strobe is active
    always_comb begin
        mem_read       = (stateQ == StFetch);
        mem_write      = (stateQ == StWrite);
        cpu_ready      = (stateQ == StResp);
        mem_address    = memAddrQ;
        mem_write_data = memWdataQ;
        if (stateQ == StFetch) begin
            mem_address = {cpu_addr[31:2], 2'b00};
        end else if (stateQ == StWrite) begin
            mem_address    = cpu_addr;
            mem_write_data = cpu_wdata;
        end
    end

    assign cpu_rdata = rdataQ;

    // Valid bits, load data and held memory-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            validQ    <= '0;
            rdataQ    <= '0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
        end else begin
            memAddrQ  <= mem_address;
            memWdataQ <= mem_write_data;
            if (acceptLoadHit) begin
                rdataQ <= dataQ[index][offset];
            end else if (fillNow) begin
                rdataQ        <= fetchWord;
                validQ[index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays: line fill on miss, word update on store hit
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (fillNow) begin
                tagQ[index]     <= tag;
                dataQ[index][0] <= mem_read_data[127:96];
                dataQ[index][1] <= mem_read_data[95:64];
                dataQ[index][2] <= mem_read_data[63:32];
                dataQ[index][3] <= mem_read_data[31:0];
            end else if (acceptStore && hit) begin
                dataQ[index][offset] <= cpu_wdata;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hitCntQ, missCntQ, writeCntQ;

    // Event counters, bumped on the edge that accepts each request
    always_ff @(posedge clk) begin
        if (reset) begin
            hitCntQ   <= '0;
            missCntQ  <= '0;
            writeCntQ <= '0;
        end else begin
            if (acceptLoadHit)  hitCntQ   <= hitCntQ + 32'd1;
            if (acceptLoadMiss) missCntQ  <= missCntQ + 32'd1;
            if (acceptStore)    writeCntQ <= writeCntQ + 32'd1;
        end
    end

    assign hit_count   = hitCntQ;
    assign miss_count  = missCntQ;
    assign write_count = writeCntQ;
`endif

endmodule
